tcp_handshake_link: RTL and testbench

- Parametrised client/server TCP connection model: three-way open handshake, FIN/ACK close, sequence/ack numbers, timeout-driven retransmission with retry limit.
- Two FSMs exchange segments over internal one-cycle channel registers (c2s, s2c).
- Per-direction drop inputs inject segment loss.
- Used as the connection-level stimulus/check block in the networking suite.

---
 rtl/tcp_handshake_link.sv | 175 +++++++++++++++++
 tb/tb_tcp_handshake_link.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/tcp_handshake_link.sv
// tcp_handshake_link: client/server TCP open/close handshake model with loss injection and retransmission.
// Define TCP_LINK_STATS_EN to add the retx_cnt/drop_cnt statistics outputs.
module tcp_handshake_link #(
  parameter int SEQ_W = 8,
  parameter int TIMEOUT = 6,
  parameter int MAX_RETRY = 2,
  parameter logic [SEQ_W-1:0] CLIENT_ISN = 8'h10,
  parameter logic [SEQ_W-1:0] SERVER_ISN = 8'h80
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       open_req,
  input  logic       close_req,
  input  logic       drop_c2s,
  input  logic       drop_s2c,
  output logic [2:0] client_state,
  output logic [2:0] server_state,
  output logic       connected,
  output logic       c2s_valid,
  output logic [1:0] c2s_type,
  output logic       s2c_valid,
  output logic [1:0] s2c_type,
`ifdef TCP_LINK_STATS_EN
  output logic [15:0] retx_cnt,
  output logic [15:0] drop_cnt,
`endif
  output logic       client_fail,
  output logic       server_fail
);
  typedef enum logic [2:0] {C_CLOSED = 3'd0, C_SYN_SENT = 3'd1, C_EST = 3'd2, C_FIN_WAIT = 3'd3} c_state_t;
  typedef enum logic [2:0] {S_LISTEN = 3'd3, S_SYN_RCVD = 3'd4, S_EST = 3'd5} s_state_t;
  localparam logic [1:0] SYN = 2'd0, SYNACK = 2'd1, ACK = 2'd2, FIN = 2'd3;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [RW-1:0] R_MAX = RW'(MAX_RETRY);
  localparam logic [SEQ_W-1:0] C1 = CLIENT_ISN + 1'b1;
  localparam logic [SEQ_W-1:0] C2 = CLIENT_ISN + 2'd2;
  localparam logic [SEQ_W-1:0] S1 = SERVER_ISN + 1'b1;
  c_state_t c_st, c_nxt;
  s_state_t s_st, s_nxt;
  logic [TW-1:0] c_tim, s_tim;
  logic [RW-1:0] c_ret, s_ret;
  logic [SEQ_W-1:0] c_srv, c_srv_n, s_cli, s_cli_n;
  logic [SEQ_W-1:0] c2s_seq, c2s_ack, s2c_seq, s2c_ack;
  logic [SEQ_W-1:0] c_sq, c_ak, s_sq, s_ak;
  logic [1:0] c_ty, s_ty;
  logic c_send, c_retx, c_fail, c_exp, s_send, s_retx, s_fail, s_exp;
  assign client_state = c_st;
  assign server_state = s_st;
  assign c_exp = (c_st == C_SYN_SENT || c_st == C_FIN_WAIT) && c_tim == T_LAST;
  assign s_exp = s_st == S_SYN_RCVD && s_tim == T_LAST;
  // A segment that the FSM acts on takes precedence over a simultaneous timer expiry.
  always_comb begin
    c_nxt = c_st;
    c_send = 1'b0;
    c_retx = 1'b0;
    c_fail = 1'b0;
    c_ty = SYN;
    c_sq = CLIENT_ISN;
    c_ak = '0;
    c_srv_n = c_srv;
    case (c_st)
      C_CLOSED: if (open_req) {c_nxt, c_send} = {C_SYN_SENT, 1'b1};
      C_SYN_SENT:
        if (s2c_valid && s2c_type == SYNACK && s2c_ack == C1) begin
          {c_nxt, c_send, c_ty, c_sq} = {C_EST, 1'b1, ACK, C1};
          c_ak = s2c_seq + 1'b1;
          c_srv_n = s2c_seq;
        end else if (c_exp) begin
          c_send = c_ret < R_MAX;
          c_retx = c_send;
          c_fail = !c_send;
          c_nxt = c_send ? C_SYN_SENT : C_CLOSED;
        end
      C_EST:
        if (s2c_valid && s2c_type == SYNACK) begin
          {c_send, c_ty, c_sq} = {1'b1, ACK, C1};
          c_ak = s2c_seq + 1'b1;
          c_srv_n = s2c_seq;
        end else if (close_req) begin
          {c_nxt, c_send, c_ty, c_sq} = {C_FIN_WAIT, 1'b1, FIN, C1};
          c_ak = c_srv + 1'b1;
        end
      C_FIN_WAIT:
        if (s2c_valid && s2c_type == ACK && s2c_ack == C2) c_nxt = C_CLOSED;
        else if (c_exp) begin
          {c_ty, c_sq} = {FIN, C1};
          c_ak = c_srv + 1'b1;
          c_send = c_ret < R_MAX;
          c_retx = c_send;
          c_fail = !c_send;
          c_nxt = c_send ? C_FIN_WAIT : C_CLOSED;
        end
      default: c_nxt = C_CLOSED;
    endcase
  end
  always_comb begin
    s_nxt = s_st;
    s_send = 1'b0;
    s_retx = 1'b0;
    s_fail = 1'b0;
    s_ty = SYNACK;
    s_sq = SERVER_ISN;
    s_ak = s_cli + 1'b1;
    s_cli_n = s_cli;
    case (s_st)
      S_LISTEN:
        if (c2s_valid && c2s_type == SYN) begin
          {s_nxt, s_send} = {S_SYN_RCVD, 1'b1};
          s_ak = c2s_seq + 1'b1;
          s_cli_n = c2s_seq;
        end
      S_SYN_RCVD:
        if (c2s_valid && c2s_type == ACK && c2s_ack == S1) s_nxt = S_EST;
        else if (c2s_valid && c2s_type == SYN) begin
          s_send = 1'b1;
          s_ak = c2s_seq + 1'b1;
          s_cli_n = c2s_seq;
        end else if (c2s_valid && c2s_type == FIN) begin
          {s_nxt, s_send, s_ty, s_sq} = {S_LISTEN, 1'b1, ACK, S1};
          s_ak = c2s_seq + 1'b1;
        end else if (s_exp) begin
          s_send = s_ret < R_MAX;
          s_retx = s_send;
          s_fail = !s_send;
          s_nxt = s_send ? S_SYN_RCVD : S_LISTEN;
        end
      S_EST:
        if (c2s_valid && c2s_type == FIN) begin
          {s_nxt, s_send, s_ty, s_sq} = {S_LISTEN, 1'b1, ACK, S1};
          s_ak = c2s_seq + 1'b1;
        end
      default: s_nxt = S_LISTEN;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      c_st <= C_CLOSED;
      s_st <= S_LISTEN;
      {c_tim, s_tim, c_ret, s_ret, c_srv, s_cli} <= '0;
      {c2s_valid, c2s_type, c2s_seq, c2s_ack} <= '0;
      {s2c_valid, s2c_type, s2c_seq, s2c_ack} <= '0;
      {connected, client_fail, server_fail} <= '0;
    end else begin
      c_st <= c_nxt;
      s_st <= s_nxt;
      c_srv <= c_srv_n;
      s_cli <= s_cli_n;
      c_tim <= (c_send || c_nxt != c_st || !(c_st == C_SYN_SENT || c_st == C_FIN_WAIT)) ? '0 : c_tim + 1'b1;
      s_tim <= (s_send || s_nxt != s_st || s_st != S_SYN_RCVD) ? '0 : s_tim + 1'b1;
      c_ret <= c_nxt != c_st ? '0 : c_ret + RW'(c_retx);
      s_ret <= s_nxt != s_st ? '0 : s_ret + RW'(s_retx);
      c2s_valid <= c_send && !drop_c2s;
      s2c_valid <= s_send && !drop_s2c;
      if (c_send) {c2s_type, c2s_seq, c2s_ack} <= {c_ty, c_sq, c_ak};
      if (s_send) {s2c_type, s2c_seq, s2c_ack} <= {s_ty, s_sq, s_ak};
      connected <= c_st == C_EST && s_st == S_EST;
      client_fail <= c_fail;
      server_fail <= s_fail;
    end
  end
`ifdef TCP_LINK_STATS_EN
  logic [16:0] retx_sum, drop_sum;
  assign retx_sum = {1'b0, retx_cnt} + 17'(c_retx) + 17'(s_retx);
  assign drop_sum = {1'b0, drop_cnt} + 17'(c_send && drop_c2s) + 17'(s_send && drop_s2c);
  always_ff @(posedge clk) begin
    if (reset) {retx_cnt, drop_cnt} <= '0;
    else begin
      retx_cnt <= retx_sum[16] ? 16'hFFFF : retx_sum[15:0];
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end
`endif
endmodule

// File: tb/tb_tcp_handshake_link.sv
// tb_tcp_handshake_link: directed-vector bench for tcp_handshake_link handshake, close, loss and reset scenarios.
module tb_tcp_handshake_link;
  logic clk = 1'b0;
  logic reset, open_req, close_req, drop_c2s, drop_s2c;
  logic [2:0] client_state, server_state;
  logic connected, c2s_valid, s2c_valid, client_fail, server_fail;
  logic [1:0] c2s_type, s2c_type;
`ifdef TCP_LINK_STATS_EN
  logic [15:0] retx_cnt, drop_cnt;
`endif
  int vecs = 0;
  int errs = 0;
  tcp_handshake_link dut (
    .clk(clk), .reset(reset), .open_req(open_req), .close_req(close_req),
    .drop_c2s(drop_c2s), .drop_s2c(drop_s2c),
    .client_state(client_state), .server_state(server_state), .connected(connected),
    .c2s_valid(c2s_valid), .c2s_type(c2s_type), .s2c_valid(s2c_valid), .s2c_type(s2c_type),
`ifdef TCP_LINK_STATS_EN
    .retx_cnt(retx_cnt), .drop_cnt(drop_cnt),
`endif
    .client_fail(client_fail), .server_fail(server_fail)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    {reset, open_req, close_req, drop_c2s, drop_s2c} = 5'b10000;
    tick();
    tick();
    reset = 1'b0;
  endtask
  task automatic test_reset;
    do_reset();
    vecs++;
    if ({client_state, server_state} !== {3'd0, 3'd3}) begin errs++; $display("FAIL reset_states: got %0d/%0d want 0/3", client_state, server_state); end
    vecs++;
    if ({connected, c2s_valid, s2c_valid, client_fail, server_fail} !== 5'b0) begin errs++; $display("FAIL reset_outputs: got %b want 00000", {connected, c2s_valid, s2c_valid, client_fail, server_fail}); end
`ifdef TCP_LINK_STATS_EN
    vecs++;
    if ({retx_cnt, drop_cnt} !== 32'd0) begin errs++; $display("FAIL reset_stats: got %0d/%0d want 0/0", retx_cnt, drop_cnt); end
`endif
  endtask
  task automatic test_open;
    do_reset();
    open_req = 1'b1;
    tick();
    open_req = 1'b0;
    vecs++;
    if ({client_state, server_state, c2s_valid, c2s_type} !== {3'd1, 3'd3, 1'b1, 2'd0}) begin errs++; $display("FAIL open_e0: got c%0d s%0d v%0d t%0d want c1 s3 v1 t0", client_state, server_state, c2s_valid, c2s_type); end
    tick();
    vecs++;
    if ({client_state, server_state, s2c_valid, s2c_type} !== {3'd1, 3'd4, 1'b1, 2'd1}) begin errs++; $display("FAIL open_e1: got c%0d s%0d v%0d t%0d want c1 s4 v1 t1", client_state, server_state, s2c_valid, s2c_type); end
    tick();
    vecs++;
    if ({client_state, server_state, c2s_valid, c2s_type} !== {3'd2, 3'd4, 1'b1, 2'd2}) begin errs++; $display("FAIL open_e2: got c%0d s%0d v%0d t%0d want c2 s4 v1 t2", client_state, server_state, c2s_valid, c2s_type); end
    tick();
    vecs++;
    if ({server_state, connected} !== {3'd5, 1'b0}) begin errs++; $display("FAIL open_e3: got s%0d conn%0d want s5 conn0", server_state, connected); end
    tick();
    vecs++;
    if (connected !== 1'b1) begin errs++; $display("FAIL open_e4_connected: got %0d want 1", connected); end
`ifdef TCP_LINK_STATS_EN
    vecs++;
    if (retx_cnt !== 16'd0) begin errs++; $display("FAIL open_retx: got %0d want 0", retx_cnt); end
`endif
  endtask
  task automatic test_close;
    close_req = 1'b1;
    tick();
    close_req = 1'b0;
    vecs++;
    if ({client_state, c2s_valid, c2s_type} !== {3'd3, 1'b1, 2'd3}) begin errs++; $display("FAIL close_fin: got c%0d v%0d t%0d want c3 v1 t3", client_state, c2s_valid, c2s_type); end
    tick();
    vecs++;
    if ({server_state, s2c_valid, s2c_type, connected} !== {3'd3, 1'b1, 2'd2, 1'b0}) begin errs++; $display("FAIL close_srv: got s%0d v%0d t%0d conn%0d want s3 v1 t2 conn0", server_state, s2c_valid, s2c_type, connected); end
    tick();
    vecs++;
    if ({client_state, connected} !== {3'd0, 1'b0}) begin errs++; $display("FAIL close_cli: got c%0d conn%0d want c0 conn0", client_state, connected); end
  endtask
  task automatic test_drop_syn;
    do_reset();
    {open_req, drop_c2s} = 2'b11;
    tick();
    {open_req, drop_c2s} = 2'b00;
    for (int i = 0; i < 6; i++) begin
      vecs++;
      if ({client_state, c2s_valid} !== {3'd1, 1'b0}) begin errs++; $display("FAIL drop_syn_wait%0d: got c%0d v%0d want c1 v0", i, client_state, c2s_valid); end
      if (i < 5) tick();
    end
    tick();
    vecs++;
    if ({c2s_valid, c2s_type} !== {1'b1, 2'd0}) begin errs++; $display("FAIL drop_syn_retx: got v%0d t%0d want v1 t0", c2s_valid, c2s_type); end
    repeat (4) tick();
    vecs++;
    if ({client_state, server_state, connected} !== {3'd2, 3'd5, 1'b1}) begin errs++; $display("FAIL drop_syn_done: got c%0d s%0d conn%0d want c2 s5 conn1", client_state, server_state, connected); end
`ifdef TCP_LINK_STATS_EN
    vecs++;
    if ({retx_cnt, drop_cnt} !== {16'd1, 16'd1}) begin errs++; $display("FAIL drop_syn_stats: got %0d/%0d want 1/1", retx_cnt, drop_cnt); end
`endif
  endtask
  task automatic test_syn_exhaust;
    int pulses = 0;
    do_reset();
    {open_req, drop_c2s} = 2'b11;
    tick();
    open_req = 1'b0;
    for (int i = 1; i <= 24; i++) begin
      tick();
      pulses += int'(client_fail);
      vecs++;
      if ({client_state, server_state, client_fail} !== {(i < 18) ? 3'd1 : 3'd0, 3'd3, i == 18}) begin errs++; $display("FAIL exhaust_e%0d: got c%0d s%0d f%0d want c%0d s3 f%0d", i, client_state, server_state, client_fail, (i < 18) ? 1 : 0, i == 18); end
    end
    drop_c2s = 1'b0;
    vecs++;
    if (pulses !== 1) begin errs++; $display("FAIL exhaust_pulses: got %0d want 1", pulses); end
`ifdef TCP_LINK_STATS_EN
    vecs++;
    if ({retx_cnt, drop_cnt} !== {16'd2, 16'd3}) begin errs++; $display("FAIL exhaust_stats: got %0d/%0d want 2/3", retx_cnt, drop_cnt); end
`endif
  endtask
  task automatic test_drop_ack;
    do_reset();
    open_req = 1'b1;
    tick();
    open_req = 1'b0;
    tick();
    drop_c2s = 1'b1;
    tick();
    drop_c2s = 1'b0;
    vecs++;
    if ({client_state, server_state, c2s_valid} !== {3'd2, 3'd4, 1'b0}) begin errs++; $display("FAIL dropack_e2: got c%0d s%0d v%0d want c2 s4 v0", client_state, server_state, c2s_valid); end
    for (int i = 3; i <= 6; i++) begin
      tick();
      vecs++;
      if ({server_state, s2c_valid} !== {3'd4, 1'b0}) begin errs++; $display("FAIL dropack_e%0d: got s%0d v%0d want s4 v0", i, server_state, s2c_valid); end
    end
    tick();
    vecs++;
    if ({server_state, s2c_valid, s2c_type} !== {3'd4, 1'b1, 2'd1}) begin errs++; $display("FAIL dropack_resynack: got s%0d v%0d t%0d want s4 v1 t1", server_state, s2c_valid, s2c_type); end
    tick();
    vecs++;
    if ({client_state, c2s_valid, c2s_type} !== {3'd2, 1'b1, 2'd2}) begin errs++; $display("FAIL dropack_reack: got c%0d v%0d t%0d want c2 v1 t2", client_state, c2s_valid, c2s_type); end
    tick();
    vecs++;
    if (server_state !== 3'd5) begin errs++; $display("FAIL dropack_srv_est: got %0d want 5", server_state); end
    tick();
    vecs++;
    if ({connected, server_fail} !== 2'b10) begin errs++; $display("FAIL dropack_connected: got conn%0d sf%0d want conn1 sf0", connected, server_fail); end
  endtask
  task automatic test_reset_mid;
    int pulses = 0;
    do_reset();
    open_req = 1'b1;
    tick();
    open_req = 1'b0;
    tick();
    vecs++;
    if ({client_state, server_state} !== {3'd1, 3'd4}) begin errs++; $display("FAIL mid_pre: got c%0d s%0d want c1 s4", client_state, server_state); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vecs++;
    if ({client_state, server_state, c2s_valid, s2c_valid, client_fail, server_fail} !== {3'd0, 3'd3, 4'b0}) begin errs++; $display("FAIL mid_reset: got c%0d s%0d v%0d%0d f%0d%0d want c0 s3 v00 f00", client_state, server_state, c2s_valid, s2c_valid, client_fail, server_fail); end
    repeat (20) begin
      tick();
      pulses += int'(client_fail) + int'(server_fail);
    end
    vecs++;
    if ({client_state, server_state, pulses} !== {3'd0, 3'd3, 32'd0}) begin errs++; $display("FAIL mid_quiet: got c%0d s%0d pulses%0d want c0 s3 pulses0", client_state, server_state, pulses); end
  endtask
  initial begin
    test_reset();
    test_open();
    test_close();
    test_drop_syn();
    test_syn_exhaust();
    test_drop_ack();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
